// File: rtl/sr_latch_cmd_sequencer.sv
// sr_latch_cmd_sequencer
//   Clocked command front-end for a WIDTH-bit gated SR latch bank. It accepts
//   SET / RESET / TOGGLE commands on a bit mask, then drives the latch Set,
//   Reset and En lines through a setup, enable pulse and hold sequence. Set
//   and Reset are never high together on any bit. Afterwards it reads back
//   the latch output Q and raises a sticky Err flag if Q disagrees with the
//   expected value on the masked bits.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous reset, active-high
//   CmdValid  in   command present
//   CmdReady  out  sequencer can accept a command (combinational)
//   CmdOp     in   2'b00 NOP, 2'b01 SET, 2'b10 RESET, 2'b11 TOGGLE
//   CmdMask   in   bits affected by the command
//   Q         in   latch output fed back from the latch bank
//   Set       out  latch Set drive
//   Reset     out  latch Reset drive
//   En        out  latch enable
//   Busy      out  sequence in progress
//   Done      out  one-cycle pulse while verifying
//   Err       out  sticky readback mismatch flag
module sr_latch_cmd_sequencer #(
  parameter int WIDTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdMask,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Set,
  output logic [WIDTH-1:0] Reset,
  output logic             En,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_VERIFY = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] set_q, set_d;
  logic [WIDTH-1:0] reset_q, reset_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept_s;
  logic             active_s;

  assign CmdReady = (state_q == ST_IDLE) & ~Rst;
  assign accept_s = CmdValid & CmdReady;
  // NOP and empty-mask commands are consumed without starting a sequence
  assign active_s = (CmdOp != OP_NOP) && (CmdMask != {WIDTH{1'b0}});

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    reset_d = reset_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        set_d   = {WIDTH{1'b0}};
        reset_d = {WIDTH{1'b0}};
        if (accept_s && active_s) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
          mask_d  = CmdMask;
          case (CmdOp)
            OP_SET: begin
              set_d = CmdMask;
              exp_d = CmdMask;
            end
            OP_RESET: begin
              reset_d = CmdMask;
              exp_d   = {WIDTH{1'b0}};
            end
            OP_TOGGLE: begin
              // Q sampled now; the two drive vectors are disjoint by construction
              set_d   = CmdMask & ~Q;
              reset_d = CmdMask & Q;
              exp_d   = ~Q;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_PULSE: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          en_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        // Data released only once En has already fallen
        state_d = ST_VERIFY;
        set_d   = {WIDTH{1'b0}};
        reset_d = {WIDTH{1'b0}};
        done_d  = 1'b1;
      end
      ST_VERIFY: begin
        state_d = ST_IDLE;
        if (((Q ^ exp_q) & mask_q) != {WIDTH{1'b0}}) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        set_d   = {WIDTH{1'b0}};
        reset_d = {WIDTH{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      set_q   <= {WIDTH{1'b0}};
      reset_q <= {WIDTH{1'b0}};
      exp_q   <= {WIDTH{1'b0}};
      mask_q  <= {WIDTH{1'b0}};
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      reset_q <= reset_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Set   = set_q;
  assign Reset = reset_q;
  assign En    = en_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Err   = err_q;

endmodule
